// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_WIDTH = 32;
  localparam int IFU_DEPTH   = 2;

  typedef logic [XLEN-1:0]        addr_t;
  typedef logic [INSTR_WIDTH-1:0] instr_t;

  localparam addr_t RESET_PC = 32'h8000_0000;

  typedef struct packed {
    addr_t  pc;
    instr_t instr;
  } entry_t;

  function automatic addr_t word_align(input addr_t a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifu_if.sv
// Instruction-memory bus, execute redirect and decode handshake of the fetch unit.
interface ifu_if;
  import ifu_pkg::*;

  logic   imem_req;
  addr_t  imem_addr;
  logic   imem_gnt;
  logic   imem_rvalid;
  instr_t imem_rdata;

  logic   redirect;
  addr_t  redirect_pc;

  logic   fd_valid;
  logic   fd_ready;
  instr_t fd_instr;
  addr_t  fd_pc;

  modport master (
    output imem_req, imem_addr, fd_valid, fd_instr, fd_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, fd_ready
  );

  modport slave (
    input  imem_req, imem_addr, fd_valid, fd_instr, fd_pc,
    output imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, fd_ready
  );

endinterface

// File: rtl/ifu_fetch_buf.sv
// Two-entry fetch queue: entries are allocated at grant, filled in order on
// response and popped from the head by decode.
module ifu_fetch_buf
  import ifu_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       flush,
  input  logic       alloc,
  input  addr_t      alloc_pc,
  input  logic       fill,
  input  instr_t     fill_instr,
  input  logic       pop,
  output logic       head_filled,
  output addr_t      head_pc,
  output instr_t     head_instr,
  output logic [1:0] count,
  output logic [1:0] unfilled
);

  // One index bit plus a wrap bit, so full and empty are distinguishable.
  logic [1:0]           alloc_ptr;
  logic [1:0]           fill_ptr;
  logic [1:0]           head_ptr;
  entry_t               entry [IFU_DEPTH];
  logic [IFU_DEPTH-1:0] filled;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      alloc_ptr <= 2'd0;
      fill_ptr  <= 2'd0;
      head_ptr  <= 2'd0;
      filled    <= '0;
      // NOTE: storage is reset as well so the decode outputs read zero after reset.
      for (int i = 0; i < IFU_DEPTH; i++) entry[i] <= '0;
    end else if (flush) begin
      alloc_ptr <= 2'd0;
      fill_ptr  <= 2'd0;
      head_ptr  <= 2'd0;
      filled    <= '0;
    end else begin
      if (alloc) begin
        entry[alloc_ptr[0]].pc <= alloc_pc;
        alloc_ptr              <= alloc_ptr + 2'd1;
      end
      // Fill and pop never target the same slot: the head is filled, the fill slot is not.
      if (fill) begin
        entry[fill_ptr[0]].instr <= fill_instr;
        filled[fill_ptr[0]]      <= 1'b1;
        fill_ptr                 <= fill_ptr + 2'd1;
      end
      if (pop) begin
        filled[head_ptr[0]] <= 1'b0;
        head_ptr            <= head_ptr + 2'd1;
      end
    end
  end

  assign head_filled = filled[head_ptr[0]];
  assign head_pc     = entry[head_ptr[0]].pc;
  assign head_instr  = entry[head_ptr[0]].instr;
  assign count       = alloc_ptr - head_ptr;
  assign unfilled    = alloc_ptr - fill_ptr;

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: program counter, credit-limited request issue,
// redirect flush and discard of responses that belong to a squashed stream.
module ifu
  import ifu_pkg::*;
(
  input  logic  clk_i,
  input  logic  rst_i,
  ifu_if.master bus
);

  addr_t      pc_q;
  addr_t      pc_d;
  logic [1:0] discard_cnt;
  logic [1:0] discard_d;
  logic       discarding;
  logic       grant;
  logic       fill;
  logic       pop;
  logic       head_filled;
  addr_t      head_pc;
  instr_t     head_instr;
  logic [1:0] count;
  logic [1:0] unfilled;

  assign discarding = (discard_cnt != 2'd0);

  // Request depends only on registered state and the redirect, never on the grant.
  assign bus.imem_req  = ~rst_i & ~bus.redirect & (count < 2'(IFU_DEPTH));
  assign bus.imem_addr = pc_q;
  assign grant         = bus.imem_req & bus.imem_gnt;

  assign fill         = bus.imem_rvalid & ~bus.redirect & ~discarding;
  assign bus.fd_valid = head_filled & ~discarding & ~bus.redirect;
  assign bus.fd_instr = head_instr;
  assign bus.fd_pc    = head_pc;
  assign pop          = bus.fd_valid & bus.fd_ready;

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    pc_d      = pc_q;
    discard_d = discard_cnt;
    if (bus.redirect) begin
      pc_d      = word_align(bus.redirect_pc);
      // Unfilled entries are still owed by memory; a response this cycle pays one of them.
      discard_d = 2'(3'(discard_cnt) + 3'(unfilled) - 3'(bus.imem_rvalid));
    end else begin
      if (grant) pc_d = pc_q + addr_t'(4);
      if (discarding && bus.imem_rvalid) discard_d = discard_cnt - 2'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst_i) begin
      pc_q        <= RESET_PC;
      discard_cnt <= 2'd0;
    end else begin
      pc_q        <= pc_d;
      discard_cnt <= discard_d;
    end
  end

  ifu_fetch_buf u_fetch_buf (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush       (bus.redirect),
    .alloc       (grant),
    .alloc_pc    (pc_q),
    .fill        (fill),
    .fill_instr  (bus.imem_rdata),
    .pop         (pop),
    .head_filled (head_filled),
    .head_pc     (head_pc),
    .head_instr  (head_instr),
    .count       (count),
    .unfilled    (unfilled)
  );

endmodule

// File: tb/tb_ifu.sv
// Bench for ifu: in-order memory model with configurable grant/latency and a
// scoreboard of the expected decode stream checked by an independent monitor.
module tb_ifu;
  import ifu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ifu_if bus ();

  ifu dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    addr_t addr;
    int    due;
  } pend_t;

  typedef struct {
    addr_t  pc;
    instr_t instr;
  } exp_t;

  int    n_tests = 0;
  int    n_fail  = 0;
  int    cyc     = 0;
  pend_t pend_q[$];
  exp_t  exp_q[$];
  addr_t exp_next;
  int    gnt_mode   = 1;  // 0 never, 1 always, 2 random
  int    lat_min    = 1;
  int    lat_max    = 1;
  int    grant_cnt  = 0;
  int    rvalid_cnt = 0;
  int    xfer_cnt   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic instr_t mem_word(input addr_t a);
    return a ^ 32'h1357_9bdf;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void push_exp();
    exp_q.push_back('{exp_next, mem_word(exp_next)});
    exp_next = exp_next + 32'd4;
  endfunction

  // Expected decode stream restarts at the word containing pc.
  task automatic start_stream(input addr_t pc);
    exp_q.delete();
    exp_next = {pc[31:2], 2'b00};
    for (int i = 0; i < 4; i++) push_exp();
  endtask

  // Cycle phases after the falling edge: +0 stimulus, +1 memory drives,
  // +2 grant capture, +3 directed checks, +4 monitor; rising edge at +5.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic do_reset();
    step();
    rst          = 1'b1;
    bus.redirect = 1'b0;
    bus.fd_ready = 1'b0;
    start_stream(RESET_PC);
    step();
    step();
    rst = 1'b0;
  endtask

  // Memory model: in-order responses, latency lat_min..lat_max after grant.
  initial begin
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        pend_q.delete();
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
      end else begin
        bus.imem_gnt = (gnt_mode == 1) || (gnt_mode == 2 && $urandom_range(1, 0) == 1);
        if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
          bus.imem_rvalid = 1'b1;
          bus.imem_rdata  = mem_word(pend_q[0].addr);
          void'(pend_q.pop_front());
          rvalid_cnt++;
        end else begin
          bus.imem_rvalid = 1'b0;
          bus.imem_rdata  = 32'hdead_beef;
        end
      end
      #1;
      if (!rst && bus.imem_req && bus.imem_gnt) begin
        pend_q.push_back('{bus.imem_addr, cyc + int'($urandom_range(lat_max, lat_min))});
        grant_cnt++;
      end
    end
  end

  // Monitor: every decode transfer is compared against the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (!rst && bus.fd_valid && bus.fd_ready) begin
        xfer_cnt++;
        e = exp_q.pop_front();
        push_exp();
        check("fd_pc", bus.fd_pc, e.pc);
        check("fd_instr", bus.fd_instr, e.instr);
      end
    end
  end

  initial begin
    addr_t got[3];
    int    n;
    int    first;
    int    n_rv;
    int    xfer_before;

    bus.fd_ready    = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    start_stream(RESET_PC);

    // Reset values.
    step();
    settle();
    check("rst_req", 32'(bus.imem_req), 32'd0);
    check("rst_valid", 32'(bus.fd_valid), 32'd0);
    check("rst_instr", bus.fd_instr, 32'd0);
    check("rst_pc", bus.fd_pc, 32'd0);
    check("rst_addr", bus.imem_addr, 32'h8000_0000);

    // Sequential fetch, 1-cycle memory, decode always ready. With two credits
    // and no same-cycle reuse of a popped entry, delivery is two per three cycles.
    gnt_mode = 1; lat_min = 1; lat_max = 1;
    do_reset();
    bus.fd_ready = 1'b1;
    settle();
    check("first_req", 32'(bus.imem_req), 32'd1);
    check("first_addr", bus.imem_addr, 32'h8000_0000);
    first = -1;
    for (int i = 1; i <= 10; i++) begin
      step();
      settle();
      if (bus.fd_valid) begin
        first = i;
        break;
      end
    end
    check("first_latency", 32'(first), 32'd2);
    n = 0;
    for (int i = 0; i < 20 && n < 3; i++) begin
      if (i > 0) begin
        step();
        settle();
      end
      if (bus.fd_valid && bus.fd_ready) begin
        got[n] = bus.fd_pc;
        n++;
      end
    end
    check("seq_count", 32'(n), 32'd3);
    check("seq_pc0", got[0], 32'h8000_0000);
    check("seq_pc1", got[1], 32'h8000_0004);
    check("seq_pc2", got[2], 32'h8000_0008);

    // Decode stalled for 5 cycles: two credits, head held stable.
    do_reset();
    grant_cnt = 0;
    repeat (4) step();
    settle();
    check("stall_grants", 32'(grant_cnt), 32'd2);
    check("stall_req_low", 32'(bus.imem_req), 32'd0);
    check("stall_valid", 32'(bus.fd_valid), 32'd1);
    check("stall_pc", bus.fd_pc, 32'h8000_0000);
    check("stall_instr", bus.fd_instr, 32'h9357_9bdf);
    step();
    bus.fd_ready = 1'b1;
    xfer_before  = xfer_cnt;
    repeat (20) step();
    settle();
    check("stall_release_progress", 32'(xfer_cnt - xfer_before >= 10), 32'd1);

    // Redirect with two fetches outstanding (4-cycle memory).
    lat_min = 4; lat_max = 4;
    do_reset();
    bus.fd_ready = 1'b1;
    step();
    step();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h8000_0102;
    start_stream(32'h8000_0100);
    settle();
    check("redir_req_low", 32'(bus.imem_req), 32'd0);
    check("redir_valid_low", 32'(bus.fd_valid), 32'd0);
    step();
    bus.redirect = 1'b0;
    settle();
    check("redir_discard2", 32'(dut.discard_cnt), 32'd2);
    check("redir_next_req", 32'(bus.imem_req), 32'd1);
    check("redir_next_addr", bus.imem_addr, 32'h8000_0100);
    n_rv  = 0;
    first = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      settle();
      if (bus.fd_valid) begin
        first = 1;
        break;
      end
      if (bus.imem_rvalid) n_rv++;
    end
    check("redir_seen_valid", 32'(first), 32'd1);
    check("redir_rvalid_before", 32'(n_rv), 32'd3);
    check("redir_first_pc", bus.fd_pc, 32'h8000_0100);
    repeat (10) step();

    // Redirect in the same cycle as a response, one fetch outstanding.
    lat_min = 1; lat_max = 1;
    gnt_mode = 0;
    do_reset();
    bus.fd_ready = 1'b1;
    gnt_mode     = 1;
    step();
    gnt_mode        = 0;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h8000_0040;
    start_stream(32'h8000_0040);
    settle();
    check("redir_rv_coincide", 32'(bus.imem_rvalid), 32'd1);
    step();
    bus.redirect = 1'b0;
    gnt_mode     = 1;
    settle();
    check("redir_rv_discard0", 32'(dut.discard_cnt), 32'd0);
    first = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      settle();
      if (bus.fd_valid) begin
        first = 1;
        break;
      end
    end
    check("redir_rv_delivered", 32'(first), 32'd1);
    check("redir_rv_pc", bus.fd_pc, 32'h8000_0040);
    repeat (10) step();

    // Reset with two fetches outstanding.
    lat_min = 4; lat_max = 4;
    do_reset();
    bus.fd_ready = 1'b1;
    step();
    step();
    rst = 1'b1;
    start_stream(RESET_PC);
    step();
    rst = 1'b0;
    settle();
    check("midrst_valid", 32'(bus.fd_valid), 32'd0);
    check("midrst_addr", bus.imem_addr, 32'h8000_0000);
    xfer_before = xfer_cnt;
    repeat (20) step();
    settle();
    check("midrst_progress", 32'(xfer_cnt > xfer_before), 32'd1);

    // Random grant, latency 1..4, decode backpressure and occasional redirects.
    gnt_mode = 2; lat_min = 1; lat_max = 4;
    do_reset();
    xfer_before = xfer_cnt;
    for (int i = 0; i < 10000; i++) begin
      step();
      bus.fd_ready = 1'($urandom_range(1, 0));
      if ($urandom_range(99, 0) == 0) begin
        bus.redirect    = 1'b1;
        bus.redirect_pc = {16'h8000, 16'($urandom)};
        start_stream(bus.redirect_pc);
      end else begin
        bus.redirect = 1'b0;
      end
    end
    step();
    bus.redirect = 1'b0;
    settle();
    check("rand_progress", 32'(xfer_cnt - xfer_before >= 1000), 32'd1);

    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
